// File: rtl/button_conditioner_if.sv
// Signal bundle between one raw setting button and its conditioner.
// The master side drives the raw button and repeat enable. The slave side
// (the conditioner) returns the conditioned strobe, the level and the repeat status.
interface button_conditioner_if;
  logic btn_in;       // raw button, asynchronous, active-high
  logic repeat_en;    // auto-repeat enable, synchronous
  logic press_pulse;  // one-cycle strobe per accepted press and per repeat
  logic btn_level;    // debounced button level
  logic repeating;    // high while auto-repeat is active

  modport master (
    output btn_in,
    output repeat_en,
    input  press_pulse,
    input  btn_level,
    input  repeating
  );

  modport slave (
    input  btn_in,
    input  repeat_en,
    output press_pulse,
    output btn_level,
    output repeating
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner for the clock-setting path.
// It synchronises the raw button through two flops and debounces both edges
// with a shared counter. It emits one press pulse per accepted press and,
// when enabled, a hold-to-repeat pulse train. All outputs are registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input logic                  CLK100MHZ,
  input logic                  reset,
  button_conditioner_if.slave  bus
);

  // Terminal counts. Every compare either leaves the state or clears the
  // counter, so the 27-bit counter can never wrap.
  localparam logic [26:0] DEB_LAST    = 27'(DEBOUNCE_CYCLES - 1);
  localparam logic [26:0] DELAY_LAST  = 27'(REPEAT_DELAY - 1);
  localparam logic [26:0] PERIOD_LAST = 27'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_ARM,
    HELD,
    REPEAT,
    REL_ARM
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic [26:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;
  logic        level_q, level_d;
  logic        rep_q, rep_d;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state, counter and output decode. Release is tested before any
  // repeat terminal count, so it wins when both happen in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 27'd1;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s2_q) state_d = PRESS_ARM;
      end

      PRESS_ARM: begin
        if (!s2_q) begin
          state_d = IDLE;          // bounce rejected
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end

      HELD: begin
        if (!s2_q) begin
          state_d = REL_ARM;
          cnt_d   = '0;
        end else if (!bus.repeat_en) begin
          cnt_d = '0;              // repeat delay only runs while enabled
        end else if (cnt_q == DELAY_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end

      REPEAT: begin
        if (!s2_q) begin
          state_d = REL_ARM;
          cnt_d   = '0;
        end else if (!bus.repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end

      REL_ARM: begin
        if (s2_q) begin
          state_d = HELD;          // release bounce: no pulse, delay restarts
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_ARM);
    rep_d   = (state_d == REPEAT);
  end

  assign bus.press_pulse = pulse_q;
  assign bus.btn_level   = level_q;
  assign bus.repeating   = rep_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with small timing parameters.
// Directed scenarios check fixed edge-indexed expectations. A randomized run
// is checked against a run-length behavioural model of the button.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic CLK100MHZ;
  logic reset;
  int   checks;
  int   fails;

  // Reference model state: synchroniser image, debounced level, repeat flag,
  // length of the current run of samples opposite to the level, and hold age.
  logic m_s1, m_s2, m_lvl, m_rep, m_pulse;
  int   m_run, m_hold;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset    (reset),
    .bus      (bif)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  // Advance one clock edge, step the behavioural model on the same inputs,
  // and return 1 time unit after the edge so outputs are settled.
  task automatic tick();
    @(posedge CLK100MHZ);
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rep = 0; m_pulse = 0;
      m_run = 0; m_hold = 0;
    end else begin
      m_pulse = 0;
      if (!m_lvl) begin
        // A press is accepted once the synchronised input stays high DEB+1 samples
        if (m_s2) begin
          m_run++;
          if (m_run == DEB + 1) begin
            m_lvl = 1; m_pulse = 1; m_run = 0; m_hold = 0; m_rep = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (!m_s2) begin
        // A release is accepted after DEB+1 low samples. Repeat stops at once.
        m_run++; m_rep = 0; m_hold = 0;
        if (m_run == DEB + 1) begin
          m_lvl = 0; m_run = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0; m_hold = 0; m_rep = 0;     // release bounce: hold age restarts
      end else if (!bif.repeat_en) begin
        m_hold = 0; m_rep = 0;
      end else begin
        m_hold++;
        if (!m_rep && m_hold == RD) begin
          m_pulse = 1; m_rep = 1; m_hold = 0;
        end else if (m_rep && m_hold == RP) begin
          m_pulse = 1; m_hold = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bif.btn_in;
    end
    #1;
  endtask

  task automatic idle_gap();
    bif.btn_in = 1'b0; bif.repeat_en = 1'b0; reset = 1'b0;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; bif.btn_in = 1'b1; bif.repeat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bif.press_pulse !== 1'b0 || bif.btn_level !== 1'b0 || bif.repeating !== 1'b0) begin
        fails++;
        $display("FAIL reset cycle %0d: pulse/level/repeating=%b/%b/%b required 0/0/0",
                 i, bif.press_pulse, bif.btn_level, bif.repeating);
      end
    end
    reset = 1'b0; bif.btn_in = 1'b0; bif.repeat_en = 1'b0;
    repeat (3) tick();
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    logic ep, el;
    bif.repeat_en = 1'b0; bif.btn_in = 1'b1;
    for (int e = 0; e < 52; e++) begin
      tick();
      if (e == 39) bif.btn_in = 1'b0;
      ep = (e == 6);
      el = (e >= 6 && e <= 45);
      checks++;
      if (bif.press_pulse !== ep || bif.btn_level !== el || bif.repeating !== 1'b0) begin
        fails++;
        $display("FAIL clean_press edge %0d: pulse/level/repeating=%b/%b/%b required %b/%b/0",
                 e, bif.press_pulse, bif.btn_level, bif.repeating, ep, el);
      end
    end
    $display("test_clean_press done");
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b1110111;
    bif.repeat_en = 1'b0; bif.btn_in = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      bif.btn_in = (e + 1 < 7) ? pat[e + 1] : 1'b0;
      checks++;
      if (bif.press_pulse !== 1'b0 || bif.btn_level !== 1'b0 || bif.repeating !== 1'b0) begin
        fails++;
        $display("FAIL bounce edge %0d: pulse/level/repeating=%b/%b/%b required 0/0/0",
                 e, bif.press_pulse, bif.btn_level, bif.repeating);
      end
    end
    $display("test_bounce done");
  endtask

  task automatic test_auto_repeat();
    logic ep, el, er;
    bif.repeat_en = 1'b1; bif.btn_in = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      ep = (e == 6) || (e >= 16 && (e - 16) % 3 == 0);
      el = (e >= 6);
      er = (e >= 16);
      checks++;
      if (bif.press_pulse !== ep || bif.btn_level !== el || bif.repeating !== er) begin
        fails++;
        $display("FAIL auto_repeat edge %0d: pulse/level/repeating=%b/%b/%b required %b/%b/%b",
                 e, bif.press_pulse, bif.btn_level, bif.repeating, ep, el, er);
      end
    end
    bif.btn_in = 1'b0;
    $display("test_auto_repeat done");
  endtask

  task automatic test_release_bounce();
    logic ep, el;
    int n;
    bif.repeat_en = 1'b0; bif.btn_in = 1'b1;
    for (int e = 0; e < 27; e++) begin
      tick();
      n = e + 1;
      bif.btn_in = !(n == 12 || n == 13 || n >= 16);
      ep = (e == 6);
      el = (e >= 6 && e <= 21);
      checks++;
      if (bif.press_pulse !== ep || bif.btn_level !== el || bif.repeating !== 1'b0) begin
        fails++;
        $display("FAIL release_bounce edge %0d: pulse/level/repeating=%b/%b/%b required %b/%b/0",
                 e, bif.press_pulse, bif.btn_level, bif.repeating, ep, el);
      end
    end
    $display("test_release_bounce done");
  endtask

  task automatic test_repeat_drop();
    logic ep, el, er;
    int n;
    bif.repeat_en = 1'b1; bif.btn_in = 1'b1;
    for (int e = 0; e < 47; e++) begin
      tick();
      n = e + 1;
      bif.repeat_en = (n < 21 || n > 30);
      ep = (e == 6 || e == 16 || e == 19 || e == 40 || e == 43 || e == 46);
      el = (e >= 6);
      er = (e >= 16 && e <= 20) || (e >= 40);
      checks++;
      if (bif.press_pulse !== ep || bif.btn_level !== el || bif.repeating !== er) begin
        fails++;
        $display("FAIL repeat_drop edge %0d: pulse/level/repeating=%b/%b/%b required %b/%b/%b",
                 e, bif.press_pulse, bif.btn_level, bif.repeating, ep, el, er);
      end
    end
    bif.btn_in = 1'b0;
    $display("test_repeat_drop done");
  endtask

  task automatic test_reset_in_repeat();
    logic ep, el, er;
    int k;
    bif.repeat_en = 1'b1; bif.btn_in = 1'b1;
    for (int e = 0; e < 41; e++) begin
      tick();
      reset = (e + 1 == 20);
      if (e == 20) begin
        ep = 0; el = 0; er = 0;
      end else begin
        k  = (e < 20) ? e : e - 21;
        ep = (k == 6 || k == 16 || k == 19);
        el = (k >= 6);
        er = (k >= 16);
      end
      checks++;
      if (bif.press_pulse !== ep || bif.btn_level !== el || bif.repeating !== er) begin
        fails++;
        $display("FAIL reset_in_repeat edge %0d: pulse/level/repeating=%b/%b/%b required %b/%b/%b",
                 e, bif.press_pulse, bif.btn_level, bif.repeating, ep, el, er);
      end
    end
    bif.btn_in = 1'b0;
    $display("test_reset_in_repeat done");
  endtask

  task automatic test_random();
    int seg;
    seg = 0;
    for (int c = 0; c < 1500; c++) begin
      if (seg == 0) begin
        seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                          : int'($urandom_range(1, 8));
        bif.btn_in = 1'($urandom_range(0, 1));
      end
      seg--;
      if ($urandom_range(0, 24) == 0) bif.repeat_en = !bif.repeat_en;
      reset = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (bif.press_pulse !== m_pulse || bif.btn_level !== m_lvl || bif.repeating !== m_rep) begin
        fails++;
        $display("FAIL random cycle %0d: pulse/level/repeating=%b/%b/%b required %b/%b/%b",
                 c, bif.press_pulse, bif.btn_level, bif.repeating, m_pulse, m_lvl, m_rep);
      end
    end
    reset = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b1; bif.btn_in = 1'b0; bif.repeat_en = 1'b0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rep = 0; m_pulse = 0; m_run = 0; m_hold = 0;
    test_reset();
    test_clean_press();
    idle_gap();
    test_bounce();
    idle_gap();
    test_auto_repeat();
    idle_gap();
    test_release_bounce();
    idle_gap();
    test_repeat_drop();
    idle_gap();
    test_reset_in_repeat();
    idle_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
